// File: rtl/proj_accumulator.sv
// rtl/proj_accumulator.sv - thresholded per-row / per-column set-pixel projection of one armed frame
// Results live in two on-chip memories read back through a registered port.
module proj_accumulator #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DATA_W = 12,
  parameter int SUM_W  = 10
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iFVAL,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  input  logic [7:0]        iTHRESH,
  input  logic [9:0]        iROW_ADDR,
  input  logic [9:0]        iCOL_ADDR,
  output logic [SUM_W-1:0]  oROW_SUM,
  output logic [SUM_W-1:0]  oCOL_SUM,
  output logic [18:0]       oPIX_TOTAL,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oOVF
);

  localparam int CAW = $clog2(H_RES);
  localparam int RAW = $clog2(V_RES + 1);
  localparam int CW1 = CAW + 1;
  localparam logic [CAW-1:0] X_LAST   = CAW'(H_RES - 1);
  localparam logic [RAW-1:0] Y_END    = RAW'(V_RES);
  localparam logic [CAW:0]   CLR_ROWS = CW1'(V_RES);
  localparam logic [9:0]     ROW_LIM  = 10'(V_RES);
  localparam logic [9:0]     COL_LIM  = 10'(H_RES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARMED, S_ACCUM, S_DRAIN1, S_DRAIN2, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [SUM_W-1:0] col_mem [2**CAW];
  logic [SUM_W-1:0] row_mem [2**RAW];

  logic             fval_d;
  logic [CAW-1:0]   clr_idx;
  logic [CAW-1:0]   x;
  logic [RAW-1:0]   y;
  logic [SUM_W-1:0] row_sum;
  logic             ca_valid;
  logic [CAW-1:0]   ca_addr;
  logic             ca_bit;
  logic [SUM_W-1:0] ca_data;

  logic pix_bit, rise, fall, y_ok, pix_go, line_end, row_commit;
  logic [SUM_W-1:0] row_add, row_wdata;
  logic unused_ok;

  function automatic logic [SUM_W-1:0] sat_inc(input logic [SUM_W-1:0] v, input logic b);
    return (b && (v != '1)) ? v + SUM_W'(1) : v;
  endfunction

  assign unused_ok  = &{1'b0, iDATA[DATA_W-9:0]};
  assign pix_bit    = iDVAL && (iDATA[DATA_W-1 -: 8] > iTHRESH);
  assign rise       = iFVAL && !fval_d;
  assign fall       = !iFVAL && fval_d;
  assign y_ok       = (y < Y_END);
  assign pix_go     = (state == S_ACCUM) && !fall && iDVAL;
  assign line_end   = pix_go && (x == X_LAST);
  assign row_add    = sat_inc(row_sum, pix_bit);
  // A short final line is committed when the frame ends mid-line.
  assign row_commit = y_ok && ((line_end) || ((state == S_ACCUM) && fall && (x != '0)));
  assign row_wdata  = line_end ? row_add : row_sum;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oBUSY     = 1'b0;
    oDONE     = 1'b0;
    case (state)
      S_IDLE:   if (iSTART) state_nxt = S_CLEAR;
      S_CLEAR: begin
        oBUSY = 1'b1;
        if (clr_idx == X_LAST) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        oBUSY = 1'b1;
        if (rise) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        oBUSY = 1'b1;
        if (fall) state_nxt = S_DRAIN1;
      end
      S_DRAIN1: begin
        oBUSY     = 1'b1;
        state_nxt = S_DRAIN2;
      end
      S_DRAIN2: begin
        oBUSY     = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        oDONE = 1'b1;
        if (iSTART) state_nxt = S_CLEAR;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      fval_d     <= 1'b0;
      clr_idx    <= '0;
      x          <= '0;
      y          <= '0;
      row_sum    <= '0;
      oPIX_TOTAL <= '0;
      oOVF       <= 1'b0;
      ca_valid   <= 1'b0;
      ca_addr    <= '0;
      ca_bit     <= 1'b0;
      ca_data    <= '0;
      oROW_SUM   <= '0;
      oCOL_SUM   <= '0;
    end else begin
      fval_d   <= iFVAL;
      clr_idx  <= (state == S_CLEAR) ? clr_idx + CAW'(1) : '0;
      // Column read stage; the write-back happens one cycle later.
      ca_valid <= pix_go && y_ok;
      ca_addr  <= x;
      ca_bit   <= pix_bit;
      ca_data  <= col_mem[x];
      case (state)
        S_CLEAR: begin
          oPIX_TOTAL <= '0;
          oOVF       <= 1'b0;
          x          <= '0;
          y          <= '0;
          row_sum    <= '0;
        end
        S_ARMED: if (rise) begin
          x       <= '0;
          y       <= '0;
          row_sum <= '0;
        end
        S_ACCUM: begin
          if (fall) begin
            row_sum <= '0;
          end else if (iDVAL) begin
            if (!y_ok) oOVF <= 1'b1;
            else if (pix_bit && (oPIX_TOTAL != '1)) oPIX_TOTAL <= oPIX_TOTAL + 19'd1;
            if (x == X_LAST) begin
              x       <= '0;
              row_sum <= '0;
              if (y != Y_END) y <= y + RAW'(1);
            end else begin
              x       <= x + CAW'(1);
              row_sum <= row_add;
            end
          end
        end
        default: ;
      endcase
      oROW_SUM <= (oBUSY || (iROW_ADDR >= ROW_LIM)) ? '0 : row_mem[iROW_ADDR[RAW-1:0]];
      oCOL_SUM <= (oBUSY || (iCOL_ADDR >= COL_LIM)) ? '0 : col_mem[iCOL_ADDR[CAW-1:0]];
    end
  end

  always_ff @(posedge iCLK) begin
    if (state == S_CLEAR) begin
      col_mem[clr_idx] <= '0;
      if ({1'b0, clr_idx} < CLR_ROWS) row_mem[RAW'(clr_idx)] <= '0;
    end else begin
      if (ca_valid)   col_mem[ca_addr] <= sat_inc(ca_data, ca_bit);
      if (row_commit) row_mem[y]       <= row_wdata;
    end
  end

endmodule

// File: doc/proj_accumulator.md
Name: proj_accumulator

Overview:
- Streaming stage directly downstream of the RAW2RGB/CCD capture path.
- Thresholds each valid camera pixel to one bit and accumulates per-row and per-column counts of set pixels for exactly one armed frame.
- Holds the results in two on-chip projection memories (row and column).
- The HPS register bridge reads those memories through a registered read port.

Parameters:
- H_RES, 640, active pixels per line; column memory depth.
- V_RES, 480, active lines per frame; row memory depth.
- DATA_W, 12, input pixel width.
- SUM_W, 10, width of each projection entry; must hold max(H_RES, V_RES).

Ports:
- iCLK  in  1  pixel clock (CCD_PIXCLK domain).
- iRST  in  1  reset, asynchronous, active-high.
- iSTART  in  1  single-cycle arm request.
- iFVAL  in  1  frame valid.
- iDVAL  in  1  pixel valid; one pixel per cycle while high.
- iDATA  in  DATA_W  pixel intensity.
- iTHRESH  in  8  threshold, compared against iDATA[DATA_W-1:DATA_W-8].
- iROW_ADDR  in  10  row memory read address.
- iCOL_ADDR  in  10  column memory read address.
- oROW_SUM  out  SUM_W  row memory read data.
- oCOL_SUM  out  SUM_W  column memory read data.
- oPIX_TOTAL  out  19  total set pixels in the frame.
- oBUSY  out  1  high in CLEAR, ARMED and ACCUM.
- oDONE  out  1  high in DONE.
- oOVF  out  1  lines beyond V_RES were seen in the frame.

Behaviour:
- Reset: state IDLE; oROW_SUM, oCOL_SUM, oPIX_TOTAL, oBUSY, oDONE and oOVF all 0; internal x/y/row-sum counters 0. Memory contents are undefined after reset until a CLEAR pass completes.
- Pixel bit: bit = (iDATA[DATA_W-1:DATA_W-8] > iTHRESH), strictly greater. bit = 0 when iDVAL = 0.
- IDLE:
  - iSTART -> CLEAR; clear index = 0.
- CLEAR:
  - Each cycle writes 0 to colMem[idx] and, if idx < V_RES, to rowMem[idx].
  - Also zeroes oPIX_TOTAL and oOVF.
  - At idx = H_RES-1 -> ARMED. Takes H_RES cycles in total.
- ARMED:
  - Waits for a rising edge of iFVAL, i.e. iFVAL sampled 0 then 1. A frame already in progress is never partially accumulated.
  - On the edge -> ACCUM with x = 0, y = 0.
- ACCUM, for each cycle with iDVAL = 1:
  - Column update is a 2-stage read-modify-write: colMem[x] <= colMem[x] + bit. Successive pixels always target distinct addresses, so no forwarding is required.
  - Row update: rowSum accumulates bit.
  - oPIX_TOTAL increments by bit.
  - x increments. When x = H_RES-1: commit rowMem[y] <= rowSum + bit, clear rowSum, x <= 0, y <= y+1.
  - Pixels with y >= V_RES are discarded and set oOVF = 1.
- ACCUM, falling edge of iFVAL:
  - If x != 0, commit the partial rowSum to rowMem[y] (if y < V_RES).
  - Drain the column pipeline (2 cycles), then -> DONE.
- DONE: oDONE = 1; iSTART -> CLEAR, i.e. a rearm.
- iSTART in CLEAR, ARMED or ACCUM is ignored.
- Read port:
  - Latency 1: oROW_SUM <= rowMem[iROW_ADDR] and oCOL_SUM <= colMem[iCOL_ADDR] on every iCLK.
  - Data is defined only in IDLE or DONE; the port outputs 0 while oBUSY = 1.
  - Out-of-range addresses (row >= V_RES, col >= H_RES) return 0.
- Arithmetic: sums saturate at 2^SUM_W-1; with default parameters this cannot be reached.
- Reset mid-operation: immediate return to IDLE, outputs to reset values. A later iSTART performs a full CLEAR.

Test Plan:
- Reset, iSTART, frame of 480x640 pixels all 0xFFF, iTHRESH = 8'h10 -> oDONE rises 2 cycles after iFVAL falls; every oROW_SUM = 640, every oCOL_SUM = 480, oPIX_TOTAL = 307200, oOVF = 0.
- Single set pixel at (x=100, y=50), all others 0, iTHRESH = 0 -> rowMem[50] = 1, colMem[100] = 1, all other entries 0, oPIX_TOTAL = 1.
- Threshold boundary: iDATA[11:4] = 8'h80 everywhere with iTHRESH = 8'h80 -> all sums 0; with iTHRESH = 8'h7F -> all row sums 640.
- iSTART asserted mid-frame (iFVAL already 1) -> block waits in ARMED; the partial frame is not counted; the next full frame is counted exactly once. iSTART pulsed during ACCUM is ignored.
- Frame of 482 lines, all set -> rows 0..479 = 640, oOVF = 1, oPIX_TOTAL = 307200. Short final line of 10 pixels in a 3-line frame -> rowMem[2] = 10.
- iRST asserted during ACCUM -> next cycle oBUSY = 0, oPIX_TOTAL = 0. A following iSTART and all-zero frame read back all zeros, proving CLEAR covers prior contents.
